weight_buffer_loader: RTL and testbench

//  Fills the psys-lane weight buffer from a word-serial weight stream (DMA/host side).

---
 rtl/weight_buffer_pkg.sv | 41 ++++
 rtl/wb_line_packer.sv | 52 +++++
 rtl/weight_buffer_loader.sv | 147 ++++++++++++++
 tb/tb_weight_buffer_loader.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_buffer_pkg.sv
// Shared definitions for the weight buffer loader and the matching buffer reader.
// Holds the derived geometry helpers (total words, line count, address and data
// port widths) and the loader FSM state encoding.
package weight_buffer_pkg;

  // Loader sequencing: wait for start, stream words, issue the last line, pulse done.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Number of weight words in a featureLen x featureLen matrix.
  function automatic int total_words(input int feature_len);
    return feature_len * feature_len;
  endfunction

  // Buffer lines needed, rounding up so a partial final line still gets a row.
  function automatic int rows(input int feature_len, input int psys);
    return (total_words(feature_len) + psys - 1) / psys;
  endfunction

  // Line address width; kept at least one bit so a single-line buffer still has a port.
  function automatic int address_width(input int feature_len, input int psys);
    int r;
    r = rows(feature_len, psys);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  // Width of one packed buffer line.
  function automatic int dataport_width(input int data_width, input int psys);
    return data_width * psys;
  endfunction

  // Width of the lane index inside a line.
  function automatic int lane_width(input int psys);
    return (psys > 1) ? $clog2(psys) : 1;
  endfunction

endpackage

// File: rtl/wb_line_packer.sv
// Line packer for the weight buffer loader.
// Collects stream words into one buffer line, one lane per word.
// Ports:
//   clk, rst : clock and asynchronous active-low reset
//   insert   : write data into lane 'lane' this cycle
//   lane     : destination lane of the incoming word
//   data     : incoming word
//   clear    : empty the line register at the next edge (takes priority over insert)
//   line     : current line contents with this cycle's word already merged in
module wb_line_packer
  import weight_buffer_pkg::*;
#(
  parameter int dataWidth = 32,
  parameter int psys      = 24,
  localparam int laneWidth = lane_width(psys),
  localparam int lineWidth = dataport_width(dataWidth, psys)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 insert,
  input  logic [laneWidth-1:0] lane,
  input  logic [dataWidth-1:0] data,
  input  logic                 clear,
  output logic [lineWidth-1:0] line
);

  logic [lineWidth-1:0] pack_q;

  // The merged view lets the loader capture a completed line on the same edge that
  // accepts its last word, which is what gives the one-cycle write latency.
  always_comb begin
    line = pack_q;
    for (int k = 0; k < psys; k++) begin
      if (insert && (lane == laneWidth'(k))) begin
        line[k*dataWidth +: dataWidth] = data;
      end
    end
  end

  // Clearing after every completed line keeps lanes that a partial final line
  // never touches at zero, so no separate masking is needed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack_q <= '0;
    end else if (clear) begin
      pack_q <= '0;
    end else begin
      pack_q <= line;
    end
  end

endmodule

// File: rtl/weight_buffer_loader.sv
// Weight buffer loader.
// Packs a word-serial weight stream into psys-word lines and writes them to the
// weight buffer at addresses 0..ROWS-1, then pulses done once the whole
// featureLen x featureLen matrix is stored.
// Ports:
//   clk, rst        : clock and asynchronous active-low reset
//   start, abort    : begin a load (IDLE only) / cancel a load in progress
//   s_valid, s_data : incoming weight stream; s_ready marks acceptance
//   wb_wren         : one-cycle buffer write strobe
//   wb_addr, wb_din : line address and packed line, held between writes
//   busy, done      : load in progress / one-cycle completion pulse
module weight_buffer_loader
  import weight_buffer_pkg::*;
#(
  parameter int dataWidth  = 32,
  parameter int featureLen = 256,
  parameter int psys       = 24,
  localparam int TOTAL_WORDS   = total_words(featureLen),
  localparam int ROWS          = rows(featureLen, psys),
  localparam int addressWidth  = address_width(featureLen, psys),
  localparam int dataportWidth = dataport_width(dataWidth, psys)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     s_valid,
  input  logic [dataWidth-1:0]     s_data,
  output logic                     s_ready,
  output logic                     wb_wren,
  output logic [addressWidth-1:0]  wb_addr,
  output logic [dataportWidth-1:0] wb_din,
  output logic                     busy,
  output logic                     done
);

  localparam int LANE_W = lane_width(psys);
  localparam int CNT_W  = $clog2(TOTAL_WORDS + 1);

  state_e                   state_q, state_d;
  logic [LANE_W-1:0]        lane_q;
  logic [addressWidth-1:0]  row_q;
  logic [CNT_W-1:0]         words_q;
  logic [dataportWidth-1:0] line_next;
  logic                     accept, last_word, line_done, restart, pack_clear;

  // An abort in the same cycle as a beat drops the beat, so nothing from that
  // cycle can reach the write port.
  assign accept     = s_valid && (state_q == LOAD) && !abort;
  assign last_word  = (words_q == CNT_W'(TOTAL_WORDS - 1));
  assign line_done  = accept && ((lane_q == LANE_W'(psys - 1)) || last_word);
  assign restart    = (state_q == IDLE) && start && !abort;
  assign pack_clear = line_done || restart || abort;

  // All status outputs decode straight from the state register.
  assign s_ready = (state_q == LOAD);
  assign busy    = (state_q == LOAD) || (state_q == FLUSH);
  assign done    = (state_q == DONE);

  wb_line_packer #(
    .dataWidth (dataWidth),
    .psys      (psys)
  ) u_packer (
    .clk    (clk),
    .rst    (rst),
    .insert (accept),
    .lane   (lane_q),
    .data   (s_data),
    .clear  (pack_clear),
    .line   (line_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FLUSH lasts exactly the cycle the final line write is on the port, so DONE
  // follows it and busy drops as done rises.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !abort) state_d = LOAD;
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else if (line_done && last_word) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (abort) begin
          state_d = IDLE;
        end else if (wb_wren) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane, row and word counters. Row stops at the last line so the address
  // never wraps even though the final line completes without a full lane count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q  <= '0;
      row_q   <= '0;
      words_q <= '0;
    end else if (restart || abort) begin
      lane_q  <= '0;
      row_q   <= '0;
      words_q <= '0;
    end else if (accept) begin
      words_q <= words_q + CNT_W'(1);
      if (line_done) begin
        lane_q <= '0;
        if (row_q != addressWidth'(ROWS - 1)) begin
          row_q <= row_q + addressWidth'(1);
        end
      end else begin
        lane_q <= lane_q + LANE_W'(1);
      end
    end
  end

  // Write port registers: strobe for one cycle after a line completes, and
  // hold address and data otherwise so the buffer side sees stable values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_wren <= 1'b0;
      wb_addr <= '0;
      wb_din  <= '0;
    end else begin
      wb_wren <= line_done;
      if (line_done) begin
        wb_addr <= row_q;
        wb_din  <= line_next;
      end
    end
  end

endmodule

// File: tb/tb_weight_buffer_loader.sv
// Bench for weight_buffer_loader: a small instance (featureLen=4, psys=3,
// dataWidth=8) checked every cycle against a line-level model, and a
// default-parameter instance run through one complete matrix load.
module tb_weight_buffer_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small instance
  logic        rst_s, start_s, abort_s, s_valid_s;
  logic [7:0]  s_data_s;
  logic        s_ready_s, wren_s, busy_s, done_s;
  logic [2:0]  addr_s;
  logic [23:0] din_s;

  // Default instance
  logic         rst_b, start_b, abort_b, s_valid_b;
  logic [31:0]  s_data_b;
  logic         s_ready_b, wren_b, busy_b, done_b;
  logic [11:0]  addr_b;
  logic [767:0] din_b;

  weight_buffer_loader #(.dataWidth(8), .featureLen(4), .psys(3)) dut_small (
    .clk(clk), .rst(rst_s), .start(start_s), .abort(abort_s),
    .s_valid(s_valid_s), .s_data(s_data_s), .s_ready(s_ready_s),
    .wb_wren(wren_s), .wb_addr(addr_s), .wb_din(din_s),
    .busy(busy_s), .done(done_s)
  );

  weight_buffer_loader dut_big (
    .clk(clk), .rst(rst_b), .start(start_b), .abort(abort_b),
    .s_valid(s_valid_b), .s_data(s_data_b), .s_ready(s_ready_b),
    .wb_wren(wren_b), .wb_addr(addr_b), .wb_din(din_b),
    .busy(busy_b), .done(done_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model of the small instance ----------------
  localparam int P = 3;
  localparam int T = 16;
  int          m_phase = 0;   // 0 idle, 1 loading, 2 final write, 3 done pulse
  int          m_n = 0;
  logic [7:0]  m_words [0:T-1];
  logic        exp_wren = 1'b0;
  logic [2:0]  exp_addr = '0;
  logic [23:0] exp_din = '0;

  function automatic logic [23:0] line_of(input int addr);
    logic [23:0] v;
    v = '0;
    for (int k = 0; k < P; k++) begin
      if (addr * P + k < T) v[k*8 +: 8] = m_words[addr * P + k];
    end
    return v;
  endfunction

  task automatic model_step(input logic st, input logic ab, input logic vl, input logic [7:0] dt);
    logic w;
    w = 1'b0;
    case (m_phase)
      0: if (st && !ab) begin m_phase = 1; m_n = 0; end
      1: begin
        if (ab) begin
          m_phase = 0;
        end else if (vl) begin
          m_words[m_n] = dt;
          m_n++;
          if ((m_n % P == 0) || (m_n == T)) begin
            w = 1'b1;
            exp_addr = 3'((m_n - 1) / P);
            exp_din = line_of((m_n - 1) / P);
          end
          if (m_n == T) m_phase = 2;
        end
      end
      2: m_phase = ab ? 0 : 3;
      default: m_phase = 0;
    endcase
    exp_wren = w;
  endtask

  // Event capture for the literal checks
  int          writes_seen, done_seen, first_addr;
  logic [23:0] din_at [0:7];

  task automatic clear_mon();
    writes_seen = 0;
    done_seen = 0;
    first_addr = -1;
    for (int i = 0; i < 8; i++) din_at[i] = '0;
  endtask

  // Compare the small instance against the model every cycle, then advance the
  // model with the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    if (!rst_s) begin
      m_phase = 0; m_n = 0; exp_wren = 1'b0; exp_addr = '0; exp_din = '0;
    end else begin
      checkOutput("s_ready", s_ready_s, m_phase == 1);
      checkOutput("wb_wren", wren_s, exp_wren);
      checkOutput("wb_addr", addr_s, exp_addr);
      checkOutput("wb_din", din_s, exp_din);
      checkOutput("busy", busy_s, (m_phase == 1) || (m_phase == 2));
      checkOutput("done", done_s, m_phase == 3);
      if (wren_s) begin
        if (first_addr < 0) first_addr = int'(addr_s);
        din_at[addr_s] = din_s;
        writes_seen++;
      end
      if (done_s) done_seen++;
      model_step(start_s, abort_s, s_valid_s, s_data_s);
    end
  end

  // ---------------- default instance monitor ----------------
  int           big_writes = 0, big_dones = 0, big_last_addr = -1, big_fails = 0;
  logic [767:0] big_last_din = '0;

  function automatic logic [767:0] big_line(input int addr);
    logic [767:0] v;
    v = '0;
    for (int k = 0; k < 24; k++) begin
      if (addr * 24 + k < 65536) v[k*32 +: 32] = 32'(addr * 24 + k + 1);
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst_b) begin
      if (wren_b) begin
        checks++;
        if (int'(addr_b) != big_writes || din_b !== big_line(big_writes)) begin
          errors++;
          big_fails++;
          if (big_fails <= 5)
            $display("[TB] FAIL big_write %0d: addr %0d din %h, expected addr %0d din %h",
                     big_writes, addr_b, din_b, big_writes, big_line(big_writes));
        end
        big_last_addr = int'(addr_b);
        big_last_din = din_b;
        big_writes++;
      end
      if (done_b) big_dones++;
    end
  end

  // ---------------- stimulus ----------------
  // Both start tasks are entered and left just after a rising edge.
  task automatic start_load();
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
  endtask

  // Feed words 1..n; gaps randomises s_valid; poke raises start while word 'poke' is offered.
  task automatic applyStimulus(input int n, input bit gaps, input int poke);
    int idx;
    idx = 0;
    for (int c = 0; c < 2000; c++) begin
      if (idx == n) break;
      s_valid_s = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_s = 8'(idx + 1);
      start_s = (idx == poke);
      @(posedge clk); #1;
      if (s_valid_s) idx++;
    end
    s_valid_s = 1'b0;
    start_s = 1'b0;
    if (idx != n) begin
      checks++; errors++;
      $display("[TB] FAIL feed_timeout: accepted %0d, expected %0d", idx, n);
    end
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(posedge clk); #1;
      if (done_seen > 0) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("[TB] FAIL done_timeout: no done within %0d cycles", limit);
    end
  endtask

  initial begin
    rst_s = 1'b0; start_s = 1'b0; abort_s = 1'b0; s_valid_s = 1'b0; s_data_s = '0;
    rst_b = 1'b0; start_b = 1'b0; abort_b = 1'b0; s_valid_b = 1'b0; s_data_b = '0;
    clear_mon();
    #3;
    checkOutput("reset_ready", s_ready_s, 0);
    checkOutput("reset_wren", wren_s, 0);
    checkOutput("reset_busy", busy_s, 0);
    checkOutput("reset_done", done_s, 0);
    checkOutput("reset_big_wren", wren_b, 0);
    @(posedge clk); #3;
    rst_s = 1'b1; rst_b = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a load, then a clean restart
    $display("[TB] reset mid-load");
    start_load();
    applyStimulus(5, 1'b0, -1);
    #2 rst_s = 1'b0;
    #1;
    checkOutput("midreset_ready", s_ready_s, 0);
    checkOutput("midreset_wren", wren_s, 0);
    checkOutput("midreset_addr", addr_s, 0);
    checkOutput("midreset_din", din_s, 0);
    checkOutput("midreset_busy", busy_s, 0);
    checkOutput("midreset_done", done_s, 0);
    @(posedge clk); #3 rst_s = 1'b1;
    @(posedge clk); #1;
    clear_mon();
    start_load();
    applyStimulus(16, 1'b0, -1);
    wait_done(40);
    checkOutput("restart_first_addr", first_addr, 0);
    checkOutput("restart_line0", din_at[0], 24'h030201);

    // Full rate
    $display("[TB] full rate");
    clear_mon();
    start_load();
    applyStimulus(16, 1'b0, -1);
    wait_done(40);
    checkOutput("full_writes", writes_seen, 6);
    checkOutput("full_dones", done_seen, 1);
    checkOutput("full_line0", din_at[0], 24'h030201);
    checkOutput("full_line5", din_at[5], 24'h000010);
    @(posedge clk); #1;
    checkOutput("full_busy_after", busy_s, 0);

    // Random gaps
    $display("[TB] random gaps");
    clear_mon();
    start_load();
    applyStimulus(16, 1'b1, -1);
    wait_done(40);
    checkOutput("gaps_writes", writes_seen, 6);
    checkOutput("gaps_line2", din_at[2], 24'h090807);
    checkOutput("gaps_line5", din_at[5], 24'h000010);

    // Abort after 7 words, then restart
    $display("[TB] abort");
    clear_mon();
    start_load();
    applyStimulus(7, 1'b0, -1);
    abort_s = 1'b1;
    @(posedge clk); #1;
    abort_s = 1'b0;
    checkOutput("abort_ready", s_ready_s, 0);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("abort_writes", writes_seen, 2);
    checkOutput("abort_dones", done_seen, 0);
    checkOutput("abort_line1", din_at[1], 24'h060504);
    clear_mon();
    start_load();
    applyStimulus(16, 1'b0, -1);
    wait_done(40);
    checkOutput("after_abort_first_addr", first_addr, 0);
    checkOutput("after_abort_line0", din_at[0], 24'h030201);

    // start in LOAD, FLUSH and DONE is ignored; start with abort in IDLE stays idle
    $display("[TB] ignored start");
    clear_mon();
    start_load();
    applyStimulus(16, 1'b0, 4);
    start_s = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_s = 1'b0;
    @(posedge clk); #1;
    checkOutput("ign_busy", busy_s, 0);
    checkOutput("ign_writes", writes_seen, 6);
    checkOutput("ign_dones", done_seen, 1);
    start_s = 1'b1; abort_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0; abort_s = 1'b0;
    checkOutput("start_abort_busy", busy_s, 0);
    checkOutput("start_abort_ready", s_ready_s, 0);
    @(posedge clk); #1;

    // Default parameters: full 256x256 matrix
    $display("[TB] default parameters");
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    checkOutput("big_ready", s_ready_b, 1);
    for (int i = 0; i < 65536; i++) begin
      s_valid_b = 1'b1;
      s_data_b = 32'(i + 1);
      @(posedge clk); #1;
    end
    s_valid_b = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (big_dones > 0) break;
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("big_writes", big_writes, 2731);
    checkOutput("big_last_addr", big_last_addr, 2730);
    checkOutput("big_last_lane15", big_last_din[511:480], 32'h10000);
    checkOutput("big_upper_zero", |big_last_din[767:512], 0);
    checkOutput("big_dones", big_dones, 1);
    checkOutput("big_busy_after", busy_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
